// File: rtl/queue_display_pkg.sv
// Shared types and seven-segment glyphs for the queue display block.
package queue_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSub,
    StDone
  } div_state_e;

  // Glyphs are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_OFF     = 7'h7F;
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Decimal digit to glyph; out-of-range codes render blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/queue_wtime_div.sv
// Waiting-time estimator: snapshots {P,T} on change and divides
// SERVICE_TIME*(P+T-1) by T with a repeated-subtraction FSM.
module queue_wtime_div #(
  parameter int unsigned SERVICE_TIME = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] pcount_i,
  input  logic [1:0] tcount_i,
  output logic [4:0] wtime_o,
  output logic       busy_o
);

  import queue_display_pkg::*;

  localparam logic [4:0] SvcTime = 5'(SERVICE_TIME);

  div_state_e state_q, state_d;
  logic [2:0] snap_p_q, snap_p_d;
  logic [1:0] snap_t_q, snap_t_d;
  logic [4:0] num_q, num_d;
  logic [4:0] den_q, den_d;
  logic [4:0] quo_q, quo_d;
  logic [4:0] wtime_q, wtime_d;
  logic       busy_q, busy_d;

  logic       changed;
  logic       is_zero;
  logic [4:0] sum;
  logic [4:0] num_load;

  assign changed  = ({pcount_i, tcount_i} != {snap_p_q, snap_t_q});
  assign is_zero  = (snap_p_q == 3'd0) || (snap_t_q == 2'd0);
  // Only consumed when both counts are non-zero, so the -1 cannot underflow.
  assign sum      = {2'b00, snap_p_q} + {3'b000, snap_t_q} - 5'd1;
  assign num_load = SvcTime * sum;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (changed) state_d = StLoad;
      StLoad:  state_d = is_zero ? StDone : StSub;
      StSub:   if (num_q < den_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    snap_p_d = snap_p_q;
    snap_t_d = snap_t_q;
    num_d    = num_q;
    den_d    = den_q;
    quo_d    = quo_q;
    wtime_d  = wtime_q;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (changed) begin
          snap_p_d = pcount_i;
          snap_t_d = tcount_i;
          busy_d   = 1'b1;
        end
      end
      StLoad: begin
        quo_d = 5'd0;
        if (!is_zero) begin
          num_d = num_load;
          den_d = {3'b000, snap_t_q};
        end
      end
      StSub: begin
        if (num_q >= den_q) begin
          num_d = num_q - den_q;
          quo_d = quo_q + 5'd1;
        end
      end
      StDone: begin
        wtime_d = quo_q;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snap_p_q <= 3'd0;
      snap_t_q <= 2'd0;
      num_q    <= 5'd0;
      den_q    <= 5'd0;
      quo_q    <= 5'd0;
      wtime_q  <= 5'd0;
      busy_q   <= 1'b0;
    end else begin
      snap_p_q <= snap_p_d;
      snap_t_q <= snap_t_d;
      num_q    <= num_d;
      den_q    <= den_d;
      quo_q    <= quo_d;
      wtime_q  <= wtime_d;
      busy_q   <= busy_d;
    end
  end

  assign wtime_o = wtime_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/queue_display.sv
// Queue status display: registers the counter outputs, estimates waiting
// time, and drives a 4-digit multiplexed seven-segment display with blink.
module queue_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_DIV    = 2500000,
  parameter int unsigned SERVICE_TIME = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] Pcount,
  input  logic [1:0] Tcount,
  input  logic       Empty_Flag,
  input  logic       Full_Flag,
  input  logic       Alarm_Flag,
  output logic [4:0] Wtime,
  output logic       Busy,
  output logic [6:0] Seg,
  output logic [3:0] An
);

  import queue_display_pkg::*;

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [2:0] p_q;
  logic [1:0] t_q;
  logic       empty_q, full_q, alarm_q;

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        scan_idx_q, scan_idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;

  logic [1:0] tens;
  logic [3:0] units;

  // Input capture: every downstream decision uses these copies
  always_ff @(posedge CLK) begin
    if (reset) begin
      p_q     <= 3'd0;
      t_q     <= 2'd0;
      empty_q <= 1'b0;
      full_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      p_q     <= Pcount;
      t_q     <= Tcount;
      empty_q <= Empty_Flag;
      full_q  <= Full_Flag;
      alarm_q <= Alarm_Flag;
    end
  end

  queue_wtime_div #(
    .SERVICE_TIME(SERVICE_TIME)
  ) u_div (
    .clk_i    (CLK),
    .reset_i  (reset),
    .pcount_i (p_q),
    .tcount_i (t_q),
    .wtime_o  (Wtime),
    .busy_o   (Busy)
  );

  // Scan counter: advance the digit index once per SCAN_DIV cycles
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  // Blink phase: toggles every BLINK_DIV cycles, parked "on" without alarm
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (alarm_q) begin
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end
    end
  end

  // Split Wtime into decimal tens and units
  always_comb begin
    tens  = 2'd0;
    units = 4'(Wtime);
    if (Wtime >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(Wtime - 5'd30);
    end else if (Wtime >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(Wtime - 5'd20);
    end else if (Wtime >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(Wtime - 5'd10);
    end
  end

  // Digit mux and glyph lookup for the currently enabled digit
  always_comb begin
    seg_d = GLYPH_BLANK;
    unique case (scan_idx_q)
      2'd0: seg_d = (t_q == 2'd0) ? GLYPH_DASH : digit_glyph(units);
      2'd1: begin
        if (t_q == 2'd0)       seg_d = GLYPH_DASH;
        else if (tens == 2'd0) seg_d = GLYPH_BLANK;
        else                   seg_d = digit_glyph({2'b00, tens});
      end
      2'd2: begin
        if (full_q)       seg_d = GLYPH_F;
        else if (empty_q) seg_d = GLYPH_E;
        else              seg_d = GLYPH_BLANK;
      end
      2'd3: seg_d = digit_glyph({1'b0, p_q});
      default: seg_d = GLYPH_BLANK;
    endcase
    an_d = ~(4'b0001 << scan_idx_q);
    if (alarm_q && !blink_on_q) an_d = 4'hF;
  end

  // Display counters and registered segment/anode outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      scan_idx_q  <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_OFF;
      an_q        <= 4'hF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;

endmodule

// File: tb/tb_queue_display.sv
// Directed bench for queue_display: vector table plus corner-case sequences.
module tb_queue_display;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLINK = 8;
  localparam int unsigned SVC   = 3;

  logic       CLK = 1'b0;
  logic       reset;
  logic [2:0] Pcount;
  logic [1:0] Tcount;
  logic       Empty_Flag, Full_Flag, Alarm_Flag;
  logic [4:0] Wtime;
  logic       Busy;
  logic [6:0] Seg;
  logic [3:0] An;

  queue_display #(
    .SCAN_DIV     (SCAN),
    .BLINK_DIV    (BLINK),
    .SERVICE_TIME (SVC)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .Pcount     (Pcount),
    .Tcount     (Tcount),
    .Empty_Flag (Empty_Flag),
    .Full_Flag  (Full_Flag),
    .Alarm_Flag (Alarm_Flag),
    .Wtime      (Wtime),
    .Busy       (Busy),
    .Seg        (Seg),
    .An         (An)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Glyph ids: 0..9 digits, 10 "E", 11 "F", 12 "-", 13 blank
  function automatic logic [6:0] glyph(input int v);
    logic [6:0] hi;
    case (v)
      0:  hi = 7'h3F;
      1:  hi = 7'h06;
      2:  hi = 7'h5B;
      3:  hi = 7'h4F;
      4:  hi = 7'h66;
      5:  hi = 7'h6D;
      6:  hi = 7'h7D;
      7:  hi = 7'h07;
      8:  hi = 7'h7F;
      9:  hi = 7'h6F;
      10: hi = 7'h79;
      11: hi = 7'h71;
      12: hi = 7'h40;
      default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [2:0] p;
    logic [1:0] t;
    logic       e;
    logic       f;
    int         wt;
    int         busy_len;
    int         g3, g2, g1, g0;
  } vec_t;

  vec_t       vecs[8];
  int         n, len, bad, run;
  logic [6:0] seen[4];
  int         exp_g[4];

  initial begin
    // p t e f wtime busy_len d3 d2 d1 d0
    vecs[0] = '{3'd2, 2'd2, 1'b0, 1'b0,  4,  7, 2, 13, 13,  4};
    vecs[1] = '{3'd7, 2'd1, 1'b0, 1'b1, 21, 24, 7, 11,  2,  1};
    vecs[2] = '{3'd5, 2'd0, 1'b1, 1'b1,  0,  2, 5, 11, 12, 12};
    vecs[3] = '{3'd0, 2'd3, 1'b1, 1'b0,  0,  2, 0, 10, 13,  0};
    vecs[4] = '{3'd4, 2'd3, 1'b0, 1'b0,  6,  9, 4, 13, 13,  6};
    vecs[5] = '{3'd7, 2'd3, 1'b0, 1'b1,  9, 12, 7, 11, 13,  9};
    vecs[6] = '{3'd3, 2'd2, 1'b1, 1'b0,  6,  9, 3, 10, 13,  6};
    vecs[7] = '{3'd6, 2'd1, 1'b0, 1'b0, 18, 21, 6, 13,  1,  8};

    reset = 1'b1; Pcount = 3'd0; Tcount = 2'd0;
    Empty_Flag = 1'b0; Full_Flag = 1'b0; Alarm_Flag = 1'b0;
    tick(); tick();
    check("rst_wtime", Wtime, 0);
    check("rst_busy", Busy, 0);
    check("rst_seg", Seg, 7'h7F);
    check("rst_an", An, 4'hF);

    // First edge out of reset enables digit 0 and holds it for SCAN cycles
    reset = 1'b0;
    tick();
    check("first_an", An, 4'b1110);
    bad = 0;
    for (int k = 1; k < SCAN; k++) begin
      tick();
      if (An !== 4'b1110) bad++;
    end
    check("scan_hold0", bad, 0);
    tick();
    check("scan_adv1", An, 4'b1101);

    for (int i = 0; i < 8; i++) begin
      Pcount = vecs[i].p; Tcount = vecs[i].t;
      Empty_Flag = vecs[i].e; Full_Flag = vecs[i].f;
      n = 0;
      while (!Busy && n < 10) begin tick(); n++; end
      check($sformatf("v%0d_busy_rise", i), Busy, 1);
      len = 0;
      while (Busy && len < 60) begin tick(); len++; end
      check($sformatf("v%0d_busy_len", i), len, vecs[i].busy_len);
      check($sformatf("v%0d_wtime", i), Wtime, vecs[i].wt);
      repeat (SCAN * 4 + 2) tick();
      for (int d = 0; d < 4; d++) seen[d] = 'x;
      bad = 0;
      for (int k = 0; k < 4 * SCAN; k++) begin
        case (An)
          4'b1110: seen[0] = Seg;
          4'b1101: seen[1] = Seg;
          4'b1011: seen[2] = Seg;
          4'b0111: seen[3] = Seg;
          default: bad++;
        endcase
        tick();
      end
      check($sformatf("v%0d_an_onehot", i), bad, 0);
      exp_g[0] = vecs[i].g0; exp_g[1] = vecs[i].g1;
      exp_g[2] = vecs[i].g2; exp_g[3] = vecs[i].g3;
      for (int d = 0; d < 4; d++)
        check($sformatf("v%0d_digit%0d", i, d), seen[d], glyph(exp_g[d]));
    end

    // Input change during SUB: old result first, then automatic restart
    Pcount = 3'd7; Tcount = 2'd1;
    n = 0;
    while (!Busy && n < 10) begin tick(); n++; end
    repeat (3) tick();
    Pcount = 3'd3;
    len = 0;
    while (Busy && len < 60) begin tick(); len++; end
    check("restart_first", Wtime, 21);
    n = 0;
    while (!Busy && n < 10) begin tick(); n++; end
    check("restart_busy", Busy, 1);
    len = 0;
    while (Busy && len < 60) begin tick(); len++; end
    check("restart_second", Wtime, 9);

    // Reset on the 5th SUB cycle of a P=7,T=1 division
    Pcount = 3'd7;
    n = 0;
    while (!Busy && n < 10) begin tick(); n++; end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midsub_wtime", Wtime, 0);
    check("midsub_busy", Busy, 0);
    check("midsub_an", An, 4'hF);
    check("midsub_seg", Seg, 7'h7F);
    reset = 1'b0;
    len = 0;
    while (len < 60 && (len < 3 || Busy)) begin tick(); len++; end
    check("post_reset_wtime", Wtime, 21);

    // Alarm blink: runs of BLINK cycles dark and scanning
    Alarm_Flag = 1'b1;
    n = 0;
    while (An !== 4'hF && n < 40) begin tick(); n++; end
    check("blink_off_seen", An, 4'hF);
    run = 0;
    while (An === 4'hF && run < 20) begin tick(); run++; end
    check("blink_off_len", run, BLINK);
    run = 0;
    while (An !== 4'hF && run < 20) begin tick(); run++; end
    check("blink_on_len", run, BLINK);
    repeat (3) tick();
    check("blink_off2", An, 4'hF);
    Alarm_Flag = 1'b0;
    tick(); tick();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (!(An == 4'b1110 || An == 4'b1101 || An == 4'b1011 || An == 4'b0111)) bad++;
      tick();
    end
    check("alarm_release", bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
